// File: rtl/picomips_core_mc.sv
// Multi-cycle picoMIPS core: FETCH/EXEC sequencing, eight n-bit registers,
// ready/valid input and output channels, multiply, relative branch and halt.
module picomips_core_mc #(
  parameter int unsigned n      = 8,
  parameter int unsigned p_size = 6,
  parameter int unsigned i_size = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  output logic [p_size-1:0] instr_addr,
  input  logic [i_size-1:0] instr_data,
  input  logic [n-1:0]      in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [n-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = 3;
  localparam int unsigned PW   = 2 * n;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_IN   = 3'b100;
  localparam logic [2:0] OP_OUT  = 3'b101;
  localparam logic [2:0] OP_BEQZ = 3'b110;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_EXEC,
    ST_WAIT_IN,
    ST_WAIT_OUT,
    ST_HALT
  } state_t;

  state_t            r_state;
  logic [p_size-1:0] r_pc;
  logic [i_size-1:0] r_ir;
  logic [n-1:0]      r_regs [NREG];
  logic [n-1:0]      r_out_data;
  logic              r_out_valid;
  logic              r_halted;

  logic [2:0]        w_op;
  logic [RW-1:0]     w_rd;
  logic [RW-1:0]     w_rs;
  logic [n-1:0]      w_imm;
  logic [p_size-1:0] w_off;
  logic [n-1:0]      w_rd_val;
  logic [n-1:0]      w_rs_val;
  logic [PW-1:0]     w_prod;
  logic [p_size-1:0] w_pc_inc;
  logic              w_rd_wr;
  logic              w_unused;

  // Instruction field decode from the latched instruction word
  assign w_op     = r_ir[i_size-1 -: 3];
  assign w_rd     = r_ir[i_size-4 -: RW];
  assign w_rs     = r_ir[RW-1:0];
  assign w_imm    = r_ir[n-1:0];
  assign w_off    = r_ir[p_size-1:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_prod   = PW'(w_rd_val) * PW'(w_rs_val);
  assign w_pc_inc = r_pc + p_size'(1);
  assign w_rd_wr  = (w_rd != '0);
  assign w_unused = ^{r_ir, w_prod[n-1:0]};

  assign instr_addr = r_pc;
  assign in_ready   = (r_state == ST_WAIT_IN);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign halted     = r_halted;

  // R0 is never written, so it reads zero from reset onwards.
  // Branch offset addition at p_size bits gives sign extension and wrap for free.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          r_ir    <= instr_data;
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (w_op)
            OP_NOP: r_pc <= w_pc_inc;
            OP_ADD: begin
              if (w_rd_wr) r_regs[w_rd] <= w_rd_val + w_rs_val;
              r_pc <= w_pc_inc;
            end
            OP_ADDI: begin
              if (w_rd_wr) r_regs[w_rd] <= w_rd_val + w_imm;
              r_pc <= w_pc_inc;
            end
            OP_MUL: begin
              if (w_rd_wr) r_regs[w_rd] <= w_prod[PW-1:n];
              r_pc <= w_pc_inc;
            end
            OP_IN: r_state <= ST_WAIT_IN;
            OP_OUT: begin
              r_out_data  <= w_rs_val;
              r_out_valid <= 1'b1;
              r_state     <= ST_WAIT_OUT;
            end
            OP_BEQZ: r_pc <= (w_rd_val == '0) ? r_pc + w_off : w_pc_inc;
            default: begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
          endcase
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            if (w_rd_wr) r_regs[w_rd] <= in_data;
            r_pc    <= w_pc_inc;
            r_state <= ST_FETCH;
          end
        end
        ST_WAIT_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pc        <= w_pc_inc;
            r_state     <= ST_FETCH;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_picomips_core_mc.sv
// Bench for picomips_core_mc: vector table, hand-timed corner sequences and
// random programs compared against an instruction-level interpreter.
module tb_picomips_core_mc;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_IN   = 3'd4;
  localparam logic [2:0] OP_OUT  = 3'd5;
  localparam logic [2:0] OP_BEQZ = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [5:0]  instr_addr;
  logic [15:0] instr_data;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        halted;

  logic [15:0] rom [64];
  logic [7:0]  in_q [$];
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  int          in_list [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign instr_data = rom[instr_addr];

  picomips_core_mc #(.n(8), .p_size(6), .i_size(16)) dut (
    .clk(clk), .n_reset(n_reset),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .halted(halted)
  );

  typedef struct {
    string      nm;
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] ro;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] imm;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                     input logic [9:0] low);
    return {op, rd, low};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] w);
    for (int i = 0; i < 64; i++) rom[i] = w;
  endtask

  task automatic do_reset;
    n_reset   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    tick;
    n_reset = 1'b1;
  endtask

  // Instruction-level interpreter: architectural state only, no cycle detail
  task automatic model_run(output int fpc, output bit done);
    int r [8];
    int pc, ii, op, rd, rs, imm, off;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 0; ii = 0; done = 1'b0;
    exp_q.delete();
    for (int s = 0; s < 1000 && !done; s++) begin
      w   = rom[pc];
      op  = int'(w[15:13]);
      rd  = int'(w[12:10]);
      rs  = int'(w[2:0]);
      imm = int'(w[7:0]);
      off = w[5] ? int'(w[5:0]) - 64 : int'(w[5:0]);
      case (op)
        0: pc = (pc + 1) % 64;
        1: begin if (rd != 0) r[rd] = (r[rd] + r[rs]) % 256; pc = (pc + 1) % 64; end
        2: begin if (rd != 0) r[rd] = (r[rd] + imm) % 256; pc = (pc + 1) % 64; end
        3: begin if (rd != 0) r[rd] = (r[rd] * r[rs]) / 256; pc = (pc + 1) % 64; end
        4: begin if (rd != 0) r[rd] = in_list[ii]; ii++; pc = (pc + 1) % 64; end
        5: begin exp_q.push_back(8'(r[rs])); pc = (pc + 1) % 64; end
        6: pc = (r[rd] == 0) ? (pc + off + 64) % 64 : (pc + 1) % 64;
        default: done = 1'b1;
      endcase
    end
    fpc = pc;
  endtask

  // Runs the DUT from reset until halted, collecting accepted outputs
  task automatic run_prog(input bit rnd, input int maxc, output int fpc);
    bit hold;
    logic [7:0] hd;
    got_q.delete();
    for (int cyc = 0; cyc < maxc; cyc++) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 1) == 1);
        in_valid  = (in_q.size() > 0) && ($urandom_range(0, 1) == 1);
      end else begin
        out_ready = 1'b1;
        in_valid  = (in_q.size() > 0);
      end
      in_data = (in_q.size() > 0) ? in_q[0] : 8'h00;
      if (in_valid && in_ready) void'(in_q.pop_front());
      if (out_valid && out_ready) got_q.push_back(out_data);
      hold = out_valid && !out_ready;
      hd   = out_data;
      tick;
      if (hold) begin
        chk("out_hold_valid", 32'(out_valid), 32'd1);
        chk("out_hold_data", 32'(out_data), 32'(hd));
      end
      if (halted) break;
    end
    chk("halt_reached", 32'(halted), 32'd1);
    fpc = int'(instr_addr);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t vt [10];
    int   fpc, mpc, nv, nr, lim, len, sel, off;
    bit   mdone;
    logic [7:0] od;
    logic [2:0] op;

    vt[0] = '{"add",      OP_ADD,  3'd1, 3'd1, 8'h05, 8'h03, 8'h00, 8'h08};
    vt[1] = '{"mul",      OP_MUL,  3'd1, 3'd1, 8'hF0, 8'h20, 8'h00, 8'h1E};
    vt[2] = '{"addi_wrap",OP_ADDI, 3'd1, 3'd1, 8'hFF, 8'h00, 8'h02, 8'h01};
    vt[3] = '{"addi_r0",  OP_ADDI, 3'd0, 3'd0, 8'h00, 8'h00, 8'h07, 8'h00};
    vt[4] = '{"add_wrap", OP_ADD,  3'd1, 3'd1, 8'h80, 8'h80, 8'h00, 8'h00};
    vt[5] = '{"mul_ff",   OP_MUL,  3'd1, 3'd1, 8'hFF, 8'hFF, 8'h00, 8'hFE};
    vt[6] = '{"nop",      OP_NOP,  3'd1, 3'd1, 8'h11, 8'h22, 8'h00, 8'h11};
    vt[7] = '{"mul_100",  OP_MUL,  3'd1, 3'd1, 8'h10, 8'h10, 8'h00, 8'h01};
    vt[8] = '{"add_self", OP_ADD,  3'd2, 3'd2, 8'h00, 8'h21, 8'h00, 8'h42};
    vt[9] = '{"addi_r3",  OP_ADDI, 3'd3, 3'd3, 8'h00, 8'h00, 8'hFF, 8'hFF};

    n_reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    fill(mk(OP_HALT, 3'd0, 10'd0));

    // Reset state and the basic ADDI/ADD/OUT/HALT timing
    rom[0] = mk(OP_ADDI, 3'd1, 10'd5);
    rom[1] = mk(OP_ADDI, 3'd2, 10'd3);
    rom[2] = mk(OP_ADD,  3'd1, 10'd2);
    rom[3] = mk(OP_OUT,  3'd0, 10'd1);
    rom[4] = mk(OP_HALT, 3'd0, 10'd0);
    tick;
    do_reset;
    chk("rst_pc", 32'(instr_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    out_ready = 1'b1;
    nv = 0; od = 8'h00;
    for (int e = 1; e <= 11; e++) begin
      tick;
      if (out_valid) begin nv++; od = out_data; end
      if (e == 10) chk("t1_halted_early", 32'(halted), 32'd0);
    end
    chk("t1_halted", 32'(halted), 32'd1);
    chk("t1_out_cycles", 32'(nv), 32'd1);
    chk("t1_out_data", 32'(od), 32'h08);
    for (int i = 0; i < 5; i++) tick;
    chk("t1_pc_frozen", 32'(instr_addr), 32'd4);
    chk("t1_still_halted", 32'(halted), 32'd1);
    out_ready = 1'b0;

    // Single-operation vector table
    foreach (vt[k]) begin
      fill(mk(OP_HALT, 3'd0, 10'd0));
      rom[0] = mk(OP_ADDI, 3'd1, {2'b00, vt[k].a});
      rom[1] = mk(OP_ADDI, 3'd2, {2'b00, vt[k].b});
      rom[2] = (vt[k].op == OP_ADDI) ? mk(OP_ADDI, vt[k].rd, {2'b00, vt[k].imm})
                                     : mk(vt[k].op, vt[k].rd, 10'd2);
      rom[3] = mk(OP_OUT, 3'd0, {7'd0, vt[k].ro});
      do_reset;
      in_q.delete();
      run_prog(1'b0, 200, fpc);
      chk({vt[k].nm, "_count"}, 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk({vt[k].nm, "_value"}, 32'(got_q[0]), 32'(vt[k].exp));
      chk({vt[k].nm, "_pc"}, 32'(fpc), 32'd4);
    end

    // IN with delayed in_valid, plus a pulse before WAIT_IN
    fill(mk(OP_HALT, 3'd0, 10'd0));
    rom[0] = mk(OP_NOP, 3'd0, 10'd0);
    rom[1] = mk(OP_IN,  3'd4, 10'd0);
    rom[2] = mk(OP_OUT, 3'd0, 10'd4);
    do_reset;
    in_valid = 1'b1; in_data = 8'h33;
    for (int i = 0; i < 3; i++) tick;
    chk("in_early_ready", 32'(in_ready), 32'd0);
    chk("in_early_pc", 32'(instr_addr), 32'd1);
    in_valid = 1'b0;
    tick;
    nr = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) nr++;
      tick;
    end
    in_valid = 1'b1; in_data = 8'h5A;
    if (in_ready) nr++;
    tick;
    in_valid = 1'b0; in_data = 8'h00;
    chk("in_ready_cycles", 32'(nr), 32'd6);
    chk("in_ready_drop", 32'(in_ready), 32'd0);
    chk("in_pc", 32'(instr_addr), 32'd2);
    out_ready = 1'b1;
    tick; tick;
    chk("in_value_out", 32'(out_data), 32'h5A);
    out_ready = 1'b0;

    // OUT held while out_ready low
    fill(mk(OP_HALT, 3'd0, 10'd0));
    rom[0] = mk(OP_ADDI, 3'd1, 10'h03C);
    rom[1] = mk(OP_OUT,  3'd0, 10'd1);
    rom[2] = mk(OP_ADDI, 3'd1, 10'd1);
    do_reset;
    for (int i = 0; i < 4; i++) tick;
    for (int i = 0; i < 4; i++) begin
      chk("out_wait_valid", 32'(out_valid), 32'd1);
      chk("out_wait_data", 32'(out_data), 32'h3C);
      tick;
    end
    chk("out_wait_valid_last", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("out_drop", 32'(out_valid), 32'd0);
    chk("out_drop_data", 32'(out_data), 32'h3C);
    chk("out_pc", 32'(instr_addr), 32'd2);
    for (int i = 0; i < 4; i++) tick;
    chk("out_retained", 32'(out_data), 32'h3C);
    chk("out_halted", 32'(halted), 32'd1);

    // BEQZ taken backward, not taken
    fill(mk(OP_NOP, 3'd0, 10'd0));
    rom[0] = mk(OP_ADDI, 3'd1, 10'd1);
    rom[1] = mk(OP_ADDI, 3'd0, 10'd7);
    rom[3] = mk(OP_BEQZ, 3'd1, 10'd5);
    rom[5] = mk(OP_BEQZ, 3'd0, 10'h03E);
    do_reset;
    for (int i = 0; i < 8; i++) tick;
    chk("beqz_not_taken", 32'(instr_addr), 32'd4);
    for (int i = 0; i < 4; i++) tick;
    chk("beqz_back", 32'(instr_addr), 32'd3);

    // PC wrap both ways and the self-loop
    for (int v = 0; v < 3; v++) begin
      fill(mk(OP_NOP, 3'd0, 10'd0));
      rom[0]  = (v == 2) ? mk(OP_BEQZ, 3'd0, 10'd0) : mk(OP_BEQZ, 3'd0, 10'h03F);
      rom[63] = (v == 0) ? mk(OP_BEQZ, 3'd0, 10'd1) : mk(OP_NOP, 3'd0, 10'd0);
      do_reset;
      tick; tick;
      chk("wrap_first", 32'(instr_addr), (v == 2) ? 32'd0 : 32'd63);
      tick; tick;
      chk("wrap_second", 32'(instr_addr), 32'd0);
    end

    // Reset in the middle of WAIT_OUT
    fill(mk(OP_HALT, 3'd0, 10'd0));
    rom[0] = mk(OP_ADDI, 3'd1, 10'd9);
    rom[1] = mk(OP_ADDI, 3'd2, 10'd4);
    rom[2] = mk(OP_OUT,  3'd0, 10'd1);
    do_reset;
    lim = 0;
    while (!out_valid && lim < 20) begin tick; lim++; end
    chk("wo_reached", 32'(out_valid), 32'd1);
    n_reset = 1'b0;
    tick;
    chk("wo_rst_valid", 32'(out_valid), 32'd0);
    chk("wo_rst_data", 32'(out_data), 32'd0);
    chk("wo_rst_ready", 32'(in_ready), 32'd0);
    chk("wo_rst_pc", 32'(instr_addr), 32'd0);
    n_reset = 1'b1;
    fill(mk(OP_HALT, 3'd0, 10'd0));
    rom[0] = mk(OP_OUT, 3'd0, 10'd1);
    rom[1] = mk(OP_OUT, 3'd0, 10'd2);
    in_q.delete();
    run_prog(1'b0, 100, fpc);
    chk("wo_regs_count", 32'(got_q.size()), 32'd2);
    foreach (got_q[i]) chk("wo_regs_zero", 32'(got_q[i]), 32'd0);

    // Reset in the middle of WAIT_IN
    fill(mk(OP_HALT, 3'd0, 10'd0));
    rom[0] = mk(OP_IN, 3'd1, 10'd0);
    do_reset;
    lim = 0;
    while (!in_ready && lim < 20) begin tick; lim++; end
    chk("wi_reached", 32'(in_ready), 32'd1);
    n_reset = 1'b0;
    in_valid = 1'b1; in_data = 8'h77;
    tick;
    in_valid = 1'b0;
    chk("wi_rst_ready", 32'(in_ready), 32'd0);
    chk("wi_rst_pc", 32'(instr_addr), 32'd0);
    n_reset = 1'b1;

    // Random programs with random handshakes against the interpreter
    for (int t = 0; t < 40; t++) begin
      fill(mk(OP_HALT, 3'd0, 10'd0));
      len = $urandom_range(4, 20);
      for (int a = 0; a < len - 1; a++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0:       op = OP_NOP;
          1, 2:    op = OP_ADD;
          3, 4, 9: op = OP_ADDI;
          5:       op = OP_MUL;
          6:       op = OP_IN;
          7:       op = OP_OUT;
          default: op = (a + 3 <= len - 1) ? OP_BEQZ : OP_OUT;
        endcase
        if (op == OP_BEQZ) begin
          off = $urandom_range(1, 3);
          rom[a] = mk(op, 3'($urandom), {4'($urandom), 6'(off)});
        end else begin
          rom[a] = mk(op, 3'($urandom), 10'($urandom));
        end
      end
      in_list.delete();
      in_q.delete();
      for (int i = 0; i < 24; i++) begin
        in_list.push_back(int'($urandom_range(0, 255)));
        in_q.push_back(8'(in_list[i]));
      end
      model_run(mpc, mdone);
      do_reset;
      run_prog(1'b1, 3000, fpc);
      chk("rnd_pc", 32'(fpc), 32'(mpc));
      chk("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        chk("rnd_out", 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
